// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle adder/subtractor built on a DIGIT-bit adder slice.
// An operation takes N = WIDTH/DIGIT steps. Operands are shifted right through
// the slice, LSB digit first. Sum digits enter the top of a partial-result
// register, so after N steps the partial register holds the full result.
// Subtraction is a + ~b + 1: b is inverted and the carry is preset to 1 at start.
module serial_add_sub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_part;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;

    logic [DIGIT:0]   w_sum;
    logic             w_cin_msb;
    logic [WIDTH-1:0] w_part_next;

    // One slice step: low digit of each operand plus the running carry.
    assign w_sum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, r_carry};

    // The carry into the top bit of the slice is recovered from that bit's sum.
    // On the final step, this is the carry into the MSB of the whole word.
    assign w_cin_msb = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_sum[DIGIT-1];

    // The new sum digit enters at the top and older digits move down.
    // This also works when N == 1.
    assign w_part_next = WIDTH'({w_sum[DIGIT-1:0], r_part} >> DIGIT);

    // Control FSM and datapath. All outputs are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_part   <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_part  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_part  <= w_part_next;
                    r_carry <= w_sum[DIGIT];
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        r_result <= w_part_next;
                        r_cout   <= w_sum[DIGIT];
                        r_ovf    <= w_cin_msb ^ w_sum[DIGIT];
                        r_zero   <= (w_part_next == '0);
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_ovf;
    assign zero     = r_zero;

endmodule
